// File: rtl/reset_seq_if.sv
// Reset sequencer bundle: request inputs and
// sequenced domain reset outputs.
interface reset_seq_if #(
  parameter int NUM_OUTS = 3
);
  logic                async_req;
  logic                sw_req;
  logic [NUM_OUTS-1:0] reset_out;
  logic                ready;
  logic [7:0]          req_count;

  modport master (
    output async_req,
    output sw_req,
    input  reset_out,
    input  ready,
    input  req_count
  );

  modport slave (
    input  async_req,
    input  sw_req,
    output reset_out,
    output ready,
    output req_count
  );
endinterface

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: synchronised release, hold stretch,
// staggered domain release and re-run on request.
module reset_seq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int NUM_OUTS    = 3,
  parameter int STEP        = 4
) (
  input logic        clk,
  input logic        rst_n,
  reset_seq_if.slave bus
);
  localparam int IW = (NUM_OUTS > 1) ?
    $clog2(NUM_OUTS) : 1;
  localparam int RW = SYNC_STAGES - 1;
  localparam logic [7:0] HOLD_LD = 8'(STRETCH - 1);
  localparam logic [7:0] STEP_LD = 8'(STEP - 1);
  localparam logic [IW-1:0] LAST_IDX =
    IW'((NUM_OUTS > 1) ? NUM_OUTS - 2 : 0);

  typedef enum logic [1:0] {
    S_RESET,
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NUM_OUTS-1:0] rout_q, rout_d;
  logic                ready_q, ready_d;
  logic [7:0]          reqc_q, reqc_d;
  logic [RW-1:0]       rsync_q, rsync_d;
  logic [SYNC_STAGES-1:0] async_q, async_d;
  logic                aprev_q, aprev_d;
  logic                cap_q, cap_d;

  logic async_req;
  logic areq_s;
  logic rel;
  logic req;

  assign async_req = bus.async_req;

  // The RESET->HOLD move of the state register is the
  // final stage of the rst_n release synchroniser.
  assign rel    = rsync_q[RW-1];
  assign areq_s = async_q[SYNC_STAGES-1];
  assign req    = (areq_s & ~aprev_q) | bus.sw_req;

  always_comb begin
    rsync_d = RW'({rsync_q, 1'b1});
    async_d = SYNC_STAGES'({async_q, cap_q});
    aprev_d = areq_s;
    cap_d   = cap_q;
    if (areq_s && !async_req) begin
      cap_d = 1'b0;
    end
  end

  // Any async_req pulse, however short, sets cap.
  always_ff @(posedge clk or negedge rst_n
              or posedge async_req) begin
    if (!rst_n) begin
      cap_q <= 1'b0;
    end else if (async_req) begin
      cap_q <= 1'b1;
    end else begin
      cap_q <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rout_d  = rout_q;
    ready_d = ready_q;
    reqc_d  = reqc_q;
    unique case (state_q)
      S_RESET: begin
        if (rel) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (NUM_OUTS == 1) begin
          state_d = S_RUN;
          rout_d  = '0;
          ready_d = 1'b1;
        end else begin
          state_d = S_RELEASE;
          idx_d   = '0;
          rout_d  = rout_q << 1;
          cnt_d   = STEP_LD;
        end
      end
      S_RELEASE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          idx_d  = idx_q + 1'b1;
          rout_d = rout_q << 1;
          cnt_d  = STEP_LD;
          if (idx_q == LAST_IDX) begin
            state_d = S_RUN;
            rout_d  = '0;
            ready_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        rout_d  = '0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_RESET;
        rout_d  = '1;
        ready_d = 1'b0;
      end
    endcase
    if (req && state_q != S_RESET) begin
      state_d = S_HOLD;
      cnt_d   = HOLD_LD;
      idx_d   = '0;
      rout_d  = '1;
      ready_d = 1'b0;
      if (reqc_q != 8'hFF) begin
        reqc_d = reqc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      rout_q  <= '1;
      ready_q <= 1'b0;
      reqc_q  <= 8'd0;
      rsync_q <= '0;
      async_q <= '0;
      aprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rout_q  <= rout_d;
      ready_q <= ready_d;
      reqc_q  <= reqc_d;
      rsync_q <= rsync_d;
      async_q <= async_d;
      aprev_q <= aprev_d;
    end
  end

  assign bus.reset_out = rout_q;
  assign bus.ready     = ready_q;
  assign bus.req_count = reqc_q;
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Scoreboard bench for reset_seq_ctrl: default build
// plus a minimal-parameter build.
module tb_reset_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_seq_if #(.NUM_OUTS(3)) bus ();
  reset_seq_if #(.NUM_OUTS(1)) bus2 ();

  reset_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  reset_seq_ctrl #(
    .SYNC_STAGES (4),
    .STRETCH     (1),
    .NUM_OUTS    (1),
    .STEP        (1)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  typedef struct {
    int         edge_n;
    logic [2:0] rout;
    logic       rdy;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mexp;
  logic [11:0] prev;
  logic [11:0] cur;

  function automatic void chk(string nm,
                              logic [31:0] got,
                              logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               nm, got, want, cyc);
    end
  endfunction

  function automatic void push(int e, logic [2:0] r,
                               logic d, int c);
    exp_q.push_back('{e, r, d, 8'(c)});
  endfunction

  function automatic void push_rel(int e, int c);
    push(e + 16, 3'b110, 1'b0, c);
    push(e + 20, 3'b100, 1'b0, c);
    push(e + 24, 3'b000, 1'b1, c);
  endfunction

  // Monitor: every output change must match the next entry.
  always @(negedge clk) begin
    cur = {bus.reset_out, bus.ready, bus.req_count};
    if (cur !== prev) begin
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %h at cyc %0d",
                   cur, cyc);
        end else begin
          mexp = exp_q.pop_front();
          chk("sb_edge", cyc, mexp.edge_n);
          chk("sb_rout", bus.reset_out, mexp.rout);
          chk("sb_ready", bus.ready, mexp.rdy);
          chk("sb_count", bus.req_count, mexp.cnt);
        end
      end
      prev = cur;
    end
  end

  task automatic drain(input int lim);
    int k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic sw_at(input int e);
    while (cyc < e - 1) @(negedge clk);
    bus.sw_req = 1'b1;
    @(posedge clk);
    #1;
    bus.sw_req = 1'b0;
  endtask

  task automatic power_on();
    int base;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    base = cyc;
    push(base + 18, 3'b110, 1'b0, 0);
    push(base + 22, 3'b100, 1'b0, 0);
    push(base + 26, 3'b000, 1'b1, 0);
    rst_n = 1'b1;
    drain(40);
  endtask

  initial begin
    int e;
    int e1;
    int e2;
    int s;
    int base2;
    rst_n = 1'b1;
    rst2_n = 1'b1;
    bus.sw_req = 1'b0;
    bus.async_req = 1'b0;
    bus2.sw_req = 1'b0;
    bus2.async_req = 1'b0;
    #1;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rout", bus.reset_out, 3'b111);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_count", bus.req_count, 8'd0);
    chk("rst2_rout", bus2.reset_out, 1'b1);
    chk("rst2_ready", bus2.ready, 1'b0);

    power_on();

    // sw_req in RUN
    e = cyc + 3;
    exp_cnt++;
    push(e, 3'b111, 1'b0, exp_cnt);
    push_rel(e, exp_cnt);
    sw_at(e);
    drain(40);

    // 1-unit glitch on async_req
    @(posedge clk);
    #3;
    e1 = cyc + 1;
    exp_cnt++;
    push(e1 + 2, 3'b111, 1'b0, exp_cnt);
    push_rel(e1 + 2, exp_cnt);
    bus.async_req = 1'b1;
    #1;
    bus.async_req = 1'b0;
    drain(40);
    chk("cap_clear", dut.cap_q, 1'b0);

    // request while reset_out = 100
    e = cyc + 3;
    exp_cnt++;
    push(e, 3'b111, 1'b0, exp_cnt);
    push(e + 16, 3'b110, 1'b0, exp_cnt);
    push(e + 20, 3'b100, 1'b0, exp_cnt);
    e2 = e + 21;
    exp_cnt++;
    push(e2, 3'b111, 1'b0, exp_cnt);
    push_rel(e2, exp_cnt);
    sw_at(e);
    sw_at(e2);
    drain(60);

    // async and sw requests landing on the same edge
    @(posedge clk);
    #3;
    e1 = cyc + 1;
    e = e1 + 2;
    exp_cnt++;
    push(e, 3'b111, 1'b0, exp_cnt);
    push_rel(e, exp_cnt);
    bus.async_req = 1'b1;
    #1;
    bus.async_req = 1'b0;
    sw_at(e);
    drain(40);

    // 300 back-to-back requests saturate the count
    s = cyc + 3;
    for (int k = 0; k < 300; k++) begin
      if (exp_cnt < 255) begin
        exp_cnt++;
        push(s + k, 3'b111, 1'b0, exp_cnt);
      end
    end
    push_rel(s + 299, exp_cnt);
    while (cyc < s - 1) @(negedge clk);
    bus.sw_req = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.sw_req = 1'b0;
    drain(400);

    // rst_n during HOLD
    e = cyc + 3;
    push(e, 3'b111, 1'b0, exp_cnt);
    sw_at(e);
    drain(5);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("hold_rst_rout", bus.reset_out, 3'b111);
    chk("hold_rst_ready", bus.ready, 1'b0);
    chk("hold_rst_count", bus.req_count, 8'd0);
    exp_cnt = 0;
    power_on();

    // rst_n during RELEASE
    e = cyc + 3;
    exp_cnt = 1;
    push(e, 3'b111, 1'b0, 1);
    push(e + 16, 3'b110, 1'b0, 1);
    push(e + 20, 3'b100, 1'b0, 1);
    sw_at(e);
    while (cyc < e + 21) @(negedge clk);
    drain(5);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rel_rst_rout", bus.reset_out, 3'b111);
    chk("rel_rst_ready", bus.ready, 1'b0);
    chk("rel_rst_count", bus.req_count, 8'd0);
    exp_cnt = 0;
    power_on();

    // minimal build: SYNC_STAGES=4, all others 1
    @(negedge clk);
    base2 = cyc;
    rst2_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      while (cyc < base2 + k) @(negedge clk);
      chk("x_rout", bus2.reset_out, (k < 5) ? 1 : 0);
      chk("x_ready", bus2.ready, (k >= 5) ? 1 : 0);
    end
    e = cyc + 2;
    while (cyc < e - 1) @(negedge clk);
    bus2.sw_req = 1'b1;
    @(posedge clk);
    #1;
    bus2.sw_req = 1'b0;
    @(negedge clk);
    chk("x_req_rout", bus2.reset_out, 1'b1);
    chk("x_req_ready", bus2.ready, 1'b0);
    chk("x_req_count", bus2.req_count, 8'd1);
    @(negedge clk);
    chk("x_rerun_rout", bus2.reset_out, 1'b0);
    chk("x_rerun_ready", bus2.ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
